// File: rtl/fib_seq_gen_if.sv
// -----------------------------------------------------------------------------
// fib_seq_gen_if
//   Output term stream of the recurrence generator.
//
//   y        term value (W bits)
//   y_valid  y holds a valid term
//   y_ready  consumer accepts y on y_valid & y_ready
//   y_last   y is the final term of the run (qualified by y_valid)
//
//   master : generator side (drives y, y_valid, y_last)
//   slave  : consumer side  (drives y_ready)
// -----------------------------------------------------------------------------
interface fib_seq_gen_if #(
    parameter int W = 32
);
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;
    logic         y_last;

    modport master (
        output y,
        output y_valid,
        output y_last,
        input  y_ready
    );

    modport slave (
        input  y,
        input  y_valid,
        input  y_last,
        output y_ready
    );
endinterface

// File: rtl/fib_seq_gen.sv
// -----------------------------------------------------------------------------
// fib_seq_gen
//   Streams n_terms terms of a Fibonacci, Tribonacci or Pell sequence built
//   from two programmable seeds. Arithmetic wraps modulo 2^W; a sticky flag
//   records whether any presented term wrapped.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; config is sampled on the start cycle
//   RUN   | presenting terms on the stream, one per handshake
//   DONE  | one-cycle done pulse, then back to IDLE
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active low
//   start_i    start request, honoured only in IDLE
//   abort_i    synchronous abort (RUN -> IDLE, no done); beats start in IDLE
//   n_terms_i  number of terms to emit (0 emits nothing)
//   seed0_i    term 0
//   seed1_i    term 1
//   mode_i     00 Fibonacci, 01 Tribonacci, 10 Pell, 11 Fibonacci
//   y_if       output term stream (master side)
//   busy_o     high while in RUN
//   done_o     one-cycle pulse after the final handshake
//   ovf_o      sticky wrap flag, cleared on start
// -----------------------------------------------------------------------------
module fib_seq_gen #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CNT_W-1:0]  n_terms_i,
    input  logic [W-1:0]      seed0_i,
    input  logic [W-1:0]      seed1_i,
    input  logic [1:0]        mode_i,
    fib_seq_gen_if.master     y_if,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o
);

    localparam logic [1:0] MODE_TRIB = 2'b01;
    localparam logic [1:0] MODE_PELL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   n_terms_q, n_terms_d;
    logic [CNT_W-1:0]   idx_q,     idx_d;
    logic [1:0]         mode_q,    mode_d;
    logic [W-1:0]       seed1_q,   seed1_d;
    // a holds the term currently presented, b and c the two before it.
    logic [W-1:0]       a_q,       a_d;
    logic [W-1:0]       b_q,       b_d;
    logic [W-1:0]       c_q,       c_d;
    logic               valid_q,   valid_d;
    logic               ovf_q,     ovf_d;

    logic [W+1:0]       a_ext;
    logic [W+1:0]       b_ext;
    logic [W+1:0]       c_ext;
    logic [W+1:0]       sum_ext;
    logic [CNT_W-1:0]   last_idx;
    logic               is_last;
    logic               hs;

    // Next term computed two bits wide of W so a wrap is visible.
    always_comb begin
        a_ext   = {2'b00, a_q};
        b_ext   = {2'b00, b_q};
        c_ext   = {2'b00, c_q};
        sum_ext = a_ext + b_ext;
        case (mode_q)
            MODE_TRIB: sum_ext = a_ext + b_ext + c_ext;
            MODE_PELL: sum_ext = (a_ext << 1) + b_ext;
            default:   sum_ext = a_ext + b_ext;
        endcase
    end

    assign last_idx = n_terms_q - CNT_W'(1);
    assign is_last  = (idx_q == last_idx);
    assign hs       = valid_q & y_if.y_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_terms_q <= '0;
            idx_q     <= '0;
            mode_q    <= '0;
            seed1_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_terms_q <= n_terms_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            seed1_q   <= seed1_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_terms_d = n_terms_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        seed1_d   = seed1_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                // abort has priority: a coincident start is dropped.
                if (!abort_i && start_i) begin
                    n_terms_d = n_terms_i;
                    mode_d    = mode_i;
                    seed1_d   = seed1_i;
                    idx_d     = '0;
                    ovf_d     = 1'b0;
                    a_d       = seed0_i;
                    b_d       = '0;
                    c_d       = '0;
                    if (n_terms_i == '0) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                    end else begin
                        state_d = S_RUN;
                        valid_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (hs) begin
                    if (is_last) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                        c_d   = b_q;
                        b_d   = a_q;
                        // Term 1 is a seed, not a recurrence result.
                        if (idx_q == '0) begin
                            a_d = seed1_q;
                        end else begin
                            a_d = sum_ext[W-1:0];
                            if (sum_ext[W+1:W] != 2'b00) begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign y_if.y       = a_q;
    assign y_if.y_valid = valid_q;
    assign y_if.y_last  = valid_q & is_last;
    assign busy_o       = (state_q == S_RUN);
    assign done_o       = (state_q == S_DONE);
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
module tb_fib_seq_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] n_terms = '0;
    logic [31:0] seed0 = '0;
    logic [31:0] seed1 = '0;
    logic        ready = 1'b0;
    logic        sel8 = 1'b0;

    logic busy32, done32, ovf32;
    logic busy8, done8, ovf8;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned exp_q[$];

    fib_seq_gen_if #(.W(32)) s32();
    fib_seq_gen_if #(.W(8))  s8();

    assign s32.y_ready = ready;
    assign s8.y_ready  = ready;

    always #5 clk = ~clk;

    fib_seq_gen #(.W(32), .CNT_W(16)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .abort_i   (abort),
        .n_terms_i (n_terms),
        .seed0_i   (seed0),
        .seed1_i   (seed1),
        .mode_i    (mode),
        .y_if      (s32.master),
        .busy_o    (busy32),
        .done_o    (done32),
        .ovf_o     (ovf32)
    );

    fib_seq_gen #(.W(8), .CNT_W(16)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .abort_i   (abort),
        .n_terms_i (n_terms),
        .seed0_i   (seed0[7:0]),
        .seed1_i   (seed1[7:0]),
        .mode_i    (mode),
        .y_if      (s8.master),
        .busy_o    (busy8),
        .done_o    (done8),
        .ovf_o     (ovf8)
    );

    logic [31:0] y_obs;
    logic        v_obs, l_obs, d_obs;
    assign y_obs = sel8 ? {24'd0, s8.y} : s32.y;
    assign v_obs = sel8 ? s8.y_valid : s32.y_valid;
    assign l_obs = sel8 ? s8.y_last  : s32.y_last;
    assign d_obs = sel8 ? done8      : done32;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start_run(input logic [1:0] m, input logic [15:0] n,
                             input logic [31:0] s0, input logic [31:0] s1);
        mode    = m;
        n_terms = n;
        seed0   = s0;
        seed1   = s1;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // pat 0: ready always high; pat 1: ready 1,0,0,1,0,0,...
    // start_at >= 0 pulses start on that cycle of the run.
    task automatic collect(input string tag, input int pat, input int start_at);
        int          got = 0;
        int          cyc = 0;
        int          hs_cyc = -10;
        bit          done_seen = 1'b0;
        bit          stalled = 1'b0;
        logic [31:0] prev_y = '0;
        while (!done_seen && cyc < 200) begin
            start = (cyc == start_at);
            ready = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (d_obs) begin
                done_seen = 1'b1;
                chk($sformatf("%s_done_lat", tag), cyc - hs_cyc, 1);
            end else if (v_obs) begin
                if (stalled) chk($sformatf("%s_hold", tag), y_obs, prev_y);
                if (ready) begin
                    if (got < exp_q.size())
                        chk($sformatf("%s_t%0d", tag, got), y_obs, exp_q[got]);
                    chk($sformatf("%s_last%0d", tag, got), l_obs, (got == exp_q.size() - 1));
                    got++;
                    hs_cyc = cyc;
                end
                stalled = !ready;
                prev_y  = y_obs;
            end
            if (!done_seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk($sformatf("%s_count", tag), got, exp_q.size());
        chk($sformatf("%s_finished", tag), done_seen, 1);
    endtask

    initial begin
        int dcount;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_y",     s32.y, 0);
        chk("rst_valid", s32.y_valid, 0);
        chk("rst_last",  s32.y_last, 0);
        chk("rst_busy",  busy32, 0);
        chk("rst_done",  done32, 0);
        chk("rst_ovf",   ovf32, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fibonacci, continuous ready
        start_run(2'b00, 16'd10, 32'd0, 32'd1);
        chk("fib_busy", busy32, 1);
        exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
        collect("fib", 0, -1);
        chk("fib_ovf", ovf32, 0);
        @(negedge clk);
        chk("fib_done_once", done32, 0);
        chk("fib_idle_busy", busy32, 0);

        // Fibonacci with stalls
        start_run(2'b00, 16'd10, 32'd0, 32'd1);
        collect("fibstall", 1, -1);
        @(negedge clk);

        // Tribonacci and Pell
        start_run(2'b01, 16'd8, 32'd0, 32'd1);
        exp_q = '{0, 1, 1, 2, 4, 7, 13, 24};
        collect("trib", 0, -1);
        @(negedge clk);
        start_run(2'b10, 16'd6, 32'd0, 32'd1);
        exp_q = '{0, 1, 2, 5, 12, 29};
        collect("pell", 0, -1);
        @(negedge clk);

        // 8-bit wrap boundary
        sel8 = 1'b1;
        start_run(2'b00, 16'd14, 32'd0, 32'd1);
        exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
        collect("w8n14", 0, -1);
        chk("w8n14_ovf", ovf8, 0);
        @(negedge clk);
        start_run(2'b00, 16'd15, 32'd0, 32'd1);
        exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};
        collect("w8n15", 0, -1);
        chk("w8n15_ovf", ovf8, 1);
        chk("w32n15_ovf", ovf32, 0);
        repeat (3) @(negedge clk);
        chk("w8_ovf_sticky", ovf8, 1);
        sel8 = 1'b0;

        // n=0: no term, done right after the start edge, ovf cleared by start
        start_run(2'b00, 16'd0, 32'd0, 32'd1);
        chk("n0_valid", s32.y_valid, 0);
        chk("n0_done",  done32, 1);
        chk("n0_ovf_clr", ovf8, 0);
        @(negedge clk);
        chk("n0_done_off", done32, 0);
        chk("n0_valid2", s32.y_valid, 0);

        // start and config changes mid-run are ignored
        start_run(2'b00, 16'd10, 32'd0, 32'd1);
        mode    = 2'b10;
        n_terms = 16'd3;
        seed0   = 32'd99;
        exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
        collect("midstart", 0, 4);
        @(negedge clk);

        // abort after three handshakes
        start_run(2'b00, 16'd10, 32'd0, 32'd1);
        ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_pre_y", s32.y, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", s32.y_valid, 0);
        chk("abort_busy",  busy32, 0);
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            if (done32) dcount++;
            @(negedge clk);
        end
        chk("abort_no_done", dcount, 0);

        // abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abst_busy",  busy32, 0);
        chk("abst_valid", s32.y_valid, 0);
        @(negedge clk);
        chk("abst_done",  done32, 0);

        // reset mid-run, then restart
        start_run(2'b00, 16'd10, 32'd5, 32'd7);
        ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_y",     s32.y, 0);
        chk("mrst_valid", s32.y_valid, 0);
        chk("mrst_last",  s32.y_last, 0);
        chk("mrst_busy",  busy32, 0);
        chk("mrst_done",  done32, 0);
        chk("mrst_ovf",   ovf32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(2'b00, 16'd5, 32'd9, 32'd4);
        exp_q = '{9, 4, 13, 17, 30};
        collect("restart", 0, -1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
